issue_dispatch_ctrl: RTL and testbench

Dispatch-side controller for the 4-in/1-out collapsing issue queue. Each cycle it decides whether a 4-wide dispatch group may enter the queue, compacts the group's valid lanes into the queue's four input ports, and keeps an occupancy count. The count is updated by dispatch, issue and branch-kill events. It sits between rename/dispatch and the issue queue: it drives the queue's load enable and tells dispatch when to stall.

---
 rtl/issue_dispatch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_issue_dispatch_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_dispatch_ctrl.sv
// issue_dispatch_ctrl
//
// Dispatch-side controller for a 4-in/1-out collapsing issue queue.
// Each cycle it decides whether the offered 4-wide dispatch group fits in
// the queue. It compacts the group's valid lanes onto the queue's input
// ports and tracks queue occupancy across dispatch, issue and branch-kill
// events. After a kill, dispatch is held off for one RECOVER cycle.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          synchronous active-low reset
//   i_req            dispatch group offered this cycle
//   i_valid4         per-lane valid mask of the group (lane 0 = oldest)
//   i_issue          queue issued one entry this cycle
//   i_kill           branch kill this cycle
//   i_kill_cnt       number of queue entries removed by the kill
//   o_accept         group accepted, dispatch may advance
//   o_en             queue load enable (same as o_accept)
//   o_lane_valid     compacted lane valids for queue inputs 1..4
//   o_pack           per output lane k, bits [2k+1:2k] = source lane index
//   o_count          current occupancy
//   o_empty          occupancy is zero
//   o_full           occupancy above SIZE-4 (a full group may not fit)
//   o_stall_cycles   saturating count of offered-but-refused cycles

module issue_dispatch_ctrl #(
  parameter int SIZE       = 32,
  parameter int WIDTH_CNT  = 6,
  parameter int WIDTH_PERF = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic [3:0]            i_valid4,
  input  logic                  i_issue,
  input  logic                  i_kill,
  input  logic [WIDTH_CNT-1:0]  i_kill_cnt,
  output logic                  o_accept,
  output logic                  o_en,
  output logic [3:0]            o_lane_valid,
  output logic [7:0]            o_pack,
  output logic [WIDTH_CNT-1:0]  o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [WIDTH_PERF-1:0] o_stall_cycles
);

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  localparam logic        [WIDTH_CNT:0]   SIZE_U = (WIDTH_CNT+1)'(SIZE);
  localparam logic        [WIDTH_CNT:0]   FULL_U = (WIDTH_CNT+1)'(SIZE - 4);
  localparam logic signed [WIDTH_CNT+1:0] SIZE_S = (WIDTH_CNT+2)'(SIZE);

  // Clamp the signed next-count into [0, SIZE]. Landing outside that range
  // means the surrounding logic broke protocol (over-issue or over-kill).
  function automatic logic [WIDTH_CNT-1:0] clamp_cnt(
    input logic signed [WIDTH_CNT+1:0] v
  );
    if (v[WIDTH_CNT+1]) begin
      return '0;
    end else if (v > SIZE_S) begin
      return SIZE_S[WIDTH_CNT-1:0];
    end else begin
      return v[WIDTH_CNT-1:0];
    end
  endfunction

  // Saturating increment for the performance counter.
  function automatic logic [WIDTH_PERF-1:0] sat_inc(
    input logic [WIDTH_PERF-1:0] v
  );
    if (&v) begin
      return v;
    end else begin
      return v + WIDTH_PERF'(1);
    end
  endfunction

  state_t                       state_p1;
  logic [WIDTH_CNT-1:0]         count_p1;
  logic                         empty_p1;
  logic                         full_p1;
  logic [WIDTH_PERF-1:0]        stall_p1;

  logic [2:0]                   n_p0;
  logic                         room_p0;
  logic                         accept_p0;
  logic                         issue_dec_p0;
  logic [7:0]                   pack_raw_p0;
  logic [3:0]                   lane_valid_p0;
  logic [7:0]                   pack_p0;
  logic signed [WIDTH_CNT+1:0]  cnt_sum_p0;
  logic [WIDTH_CNT-1:0]         count_nxt_p0;

  // ---- p0: combinational decision from inputs, state and count ----
  assign n_p0 = {2'b00, i_valid4[0]} + {2'b00, i_valid4[1]}
              + {2'b00, i_valid4[2]} + {2'b00, i_valid4[3]};

  // Space check ignores a same-cycle issue, so it is conservative.
  assign room_p0   = ({1'b0, count_p1} + (WIDTH_CNT+1)'(n_p0)) <= SIZE_U;
  assign accept_p0 = i_req & (state_p1 == RUN) & ~i_kill & room_p0;

  // Output lane k takes the k-th set bit of the mask, oldest first.
  always_comb begin : compact
    int k;
    pack_raw_p0 = '0;
    k           = 0;
    for (int s = 0; s < 4; s++) begin
      if (i_valid4[s]) begin
        pack_raw_p0[2*k +: 2] = 2'(s);
        k = k + 1;
      end
    end
  end

  always_comb begin
    lane_valid_p0 = '0;
    for (int k = 0; k < 4; k++) begin
      lane_valid_p0[k] = accept_p0 & (3'(k) < n_p0);
    end
  end

  // Unused lanes already carry 0; a refused group presents nothing.
  assign pack_p0 = accept_p0 ? pack_raw_p0 : 8'h00;

  // An issue against an empty queue is a no-op.
  assign issue_dec_p0 = i_issue & (count_p1 != '0);

  assign cnt_sum_p0 = $signed({2'b00, count_p1})
                    + $signed((WIDTH_CNT+2)'(accept_p0 ? n_p0 : 3'd0))
                    - $signed((WIDTH_CNT+2)'(issue_dec_p0))
                    - $signed((WIDTH_CNT+2)'(i_kill ? i_kill_cnt : '0));

  assign count_nxt_p0 = clamp_cnt(cnt_sum_p0);

  // ---- p1: registered state, occupancy flags and stall counter ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_p1 <= RUN;
      count_p1 <= '0;
      empty_p1 <= 1'b1;
      full_p1  <= 1'b0;
      stall_p1 <= '0;
    end else begin
      case (state_p1)
        RUN:     if (i_kill) state_p1 <= RECOVER;
        RECOVER: state_p1 <= i_kill ? RECOVER : RUN;
        default: state_p1 <= RUN;
      endcase
      count_p1 <= count_nxt_p0;
      empty_p1 <= (count_nxt_p0 == '0);
      full_p1  <= ({1'b0, count_nxt_p0} > FULL_U);
      if (i_req & ~accept_p0) begin
        stall_p1 <= sat_inc(stall_p1);
      end
    end
  end

  assign o_accept       = accept_p0;
  assign o_en           = accept_p0;
  assign o_lane_valid   = lane_valid_p0;
  assign o_pack         = pack_p0;
  assign o_count        = count_p1;
  assign o_empty        = empty_p1;
  assign o_full         = full_p1;
  assign o_stall_cycles = stall_p1;

endmodule

// File: tb/tb_issue_dispatch_ctrl.sv
// Directed testbench for issue_dispatch_ctrl (SIZE=32). Inputs are driven
// shortly after each rising edge. Combinational outputs are checked before
// the next edge, and registered outputs are checked just after it.
module tb_issue_dispatch_ctrl;

  localparam int SIZE = 32;
  localparam int WC   = 6;
  localparam int WP   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic [3:0]    valid4;
  logic          issue;
  logic          kill;
  logic [WC-1:0] kill_cnt;
  logic          accept;
  logic          en;
  logic [3:0]    lane_valid;
  logic [7:0]    pack;
  logic [WC-1:0] count;
  logic          empty;
  logic          full;
  logic [WP-1:0] stall;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  issue_dispatch_ctrl #(
    .SIZE(SIZE), .WIDTH_CNT(WC), .WIDTH_PERF(WP)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(req),
    .i_valid4(valid4),
    .i_issue(issue),
    .i_kill(kill),
    .i_kill_cnt(kill_cnt),
    .o_accept(accept),
    .o_en(en),
    .o_lane_valid(lane_valid),
    .o_pack(pack),
    .o_count(count),
    .o_empty(empty),
    .o_full(full),
    .o_stall_cycles(stall)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic [3:0] v, input logic iss,
                     input logic k, input logic [WC-1:0] kc);
    req = r; valid4 = v; issue = iss; kill = k; kill_cnt = kc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 4'h0, 1'b0, 1'b0, '0);
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_accept", 32'(accept), 32'd0);
    rst_n = 1'b1;

    // Fill with eight full groups.
    for (int g = 0; g < 8; g++) begin
      drv(1'b1, 4'hF, 1'b0, 1'b0, '0);
      chk("fill_accept", 32'(accept), 32'd1);
      chk("fill_en", 32'(en), 32'd1);
      if (g == 0) begin
        chk("fill_lanes", 32'(lane_valid), 32'hF);
        chk("fill_pack", 32'(pack), 32'hE4);
      end
      tick();
    end
    chk("fill_count", 32'(count), 32'd32);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_empty", 32'(empty), 32'd0);

    // Queue full: refused, stall counter climbs.
    for (int s = 1; s <= 3; s++) begin
      drv(1'b1, 4'hF, 1'b0, 1'b0, '0);
      chk("full_accept", 32'(accept), 32'd0);
      chk("full_en", 32'(en), 32'd0);
      chk("full_lanes", 32'(lane_valid), 32'h0);
      chk("full_pack", 32'(pack), 32'h0);
      tick();
      chk("full_stall", 32'(stall), 32'(s));
    end

    // Boundary at SIZE-1.
    drv(1'b0, 4'h0, 1'b1, 1'b0, '0);
    tick();
    chk("b_count31", 32'(count), 32'd31);
    chk("b_full31", 32'(full), 32'd1);
    drv(1'b1, 4'b0001, 1'b0, 1'b0, '0);
    chk("b_acc_n1", 32'(accept), 32'd1);
    chk("b_lanes_n1", 32'(lane_valid), 32'b0001);
    chk("b_pack_n1", 32'(pack), 32'h00);
    tick();
    chk("b_count32", 32'(count), 32'd32);
    drv(1'b1, 4'b0011, 1'b1, 1'b0, '0);
    chk("b_acc_n2_full", 32'(accept), 32'd0);
    tick();
    chk("b_count_iss", 32'(count), 32'd31);
    chk("b_stall4", 32'(stall), 32'd4);
    drv(1'b1, 4'b0011, 1'b0, 1'b0, '0);
    chk("b_acc_n2_31", 32'(accept), 32'd0);
    tick();
    chk("b_stall5", 32'(stall), 32'd5);

    // Reset, then compaction patterns.
    rst_n = 1'b0;
    drv(1'b0, 4'h0, 1'b0, 1'b0, '0);
    tick();
    rst_n = 1'b1;
    chk("r2_count", 32'(count), 32'd0);
    chk("r2_stall", 32'(stall), 32'd0);
    drv(1'b1, 4'b1010, 1'b0, 1'b0, '0);
    chk("pk_1010", 32'(pack), 32'h0D);
    chk("lv_1010", 32'(lane_valid), 32'b0011);
    tick();
    drv(1'b1, 4'b0110, 1'b0, 1'b0, '0);
    chk("pk_0110", 32'(pack), 32'h09);
    chk("lv_0110", 32'(lane_valid), 32'b0011);
    tick();
    drv(1'b1, 4'b1001, 1'b0, 1'b0, '0);
    chk("pk_1001", 32'(pack), 32'h0C);
    chk("lv_1001", 32'(lane_valid), 32'b0011);
    tick();
    chk("pk_count", 32'(count), 32'd6);
    drv(1'b1, 4'hF, 1'b0, 1'b0, '0);
    tick();
    chk("k_count10", 32'(count), 32'd10);

    // Kill with issue at count 10.
    drv(1'b1, 4'hF, 1'b1, 1'b1, 6'd6);
    chk("k_acc_kill", 32'(accept), 32'd0);
    chk("k_en_kill", 32'(en), 32'd0);
    tick();
    chk("k_count3", 32'(count), 32'd3);
    drv(1'b1, 4'hF, 1'b0, 1'b0, '0);
    chk("k_acc_recover", 32'(accept), 32'd0);
    tick();
    chk("k_count3b", 32'(count), 32'd3);
    drv(1'b1, 4'hF, 1'b0, 1'b0, '0);
    chk("k_acc_resume", 32'(accept), 32'd1);
    tick();
    chk("k_count7", 32'(count), 32'd7);
    chk("k_stall2", 32'(stall), 32'd2);

    // Back-to-back kills.
    drv(1'b1, 4'b0001, 1'b0, 1'b1, 6'd1);
    chk("bb_acc1", 32'(accept), 32'd0);
    tick();
    chk("bb_count6", 32'(count), 32'd6);
    drv(1'b1, 4'b0001, 1'b0, 1'b1, 6'd1);
    chk("bb_acc2", 32'(accept), 32'd0);
    tick();
    chk("bb_count5", 32'(count), 32'd5);
    drv(1'b1, 4'b0001, 1'b0, 1'b0, '0);
    chk("bb_acc_recover", 32'(accept), 32'd0);
    tick();
    drv(1'b1, 4'b0001, 1'b0, 1'b0, '0);
    chk("bb_acc_resume", 32'(accept), 32'd1);
    tick();
    chk("bb_count6b", 32'(count), 32'd6);
    chk("bb_stall5", 32'(stall), 32'd5);

    // Drain by kill, then issue on an empty queue.
    drv(1'b0, 4'h0, 1'b0, 1'b1, 6'd6);
    tick();
    chk("e_count0", 32'(count), 32'd0);
    chk("e_empty", 32'(empty), 32'd1);
    drv(1'b0, 4'h0, 1'b1, 1'b0, '0);
    tick();
    chk("e_iss_count", 32'(count), 32'd0);
    chk("e_iss_empty", 32'(empty), 32'd1);
    drv(1'b1, 4'h0, 1'b0, 1'b0, '0);
    chk("e_acc_n0", 32'(accept), 32'd1);
    chk("e_lanes_n0", 32'(lane_valid), 32'h0);
    tick();
    chk("e_count_n0", 32'(count), 32'd0);

    // Fill to 20, then reset while a group is being accepted.
    for (int g = 0; g < 5; g++) begin
      drv(1'b1, 4'hF, 1'b0, 1'b0, '0);
      tick();
    end
    chk("m_count20", 32'(count), 32'd20);
    chk("m_empty", 32'(empty), 32'd0);
    rst_n = 1'b0;
    drv(1'b1, 4'hF, 1'b0, 1'b0, '0);
    chk("m_acc_in_rst", 32'(accept), 32'd1);
    tick();
    rst_n = 1'b1;
    drv(1'b0, 4'h0, 1'b0, 1'b0, '0);
    chk("m_count0", 32'(count), 32'd0);
    chk("m_empty1", 32'(empty), 32'd1);
    chk("m_stall0", 32'(stall), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
